// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux through the enabled channels, waits for
// the mux output to settle on each one, and captures one bit per channel.
// Ports: clk, rst (async, active-high), start, mask[3:0], y_in
//        -> sel0, sel1, sample[3:0], busy, done, valid (all registered).
module mux_scan_ctrl #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       y_in,
  output logic       sel0,
  output logic       sel1,
  output logic [3:0] sample,
  output logic       busy,
  output logic       done,
  output logic       valid
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FINISH
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);
  localparam logic [7:0] CNT_SMP  = 8'(SETTLE);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] mask_q;
  logic [1:0] sel;

  logic [1:0] first_ch;
  logic [1:0] next_ch;
  logic       has_next;

  assign sel0 = sel[0];
  assign sel1 = sel[1];

  // Descending loops so the last hit is the lowest qualifying channel.
  always_comb begin
    first_ch = 2'd0;
    next_ch  = sel;
    has_next = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) first_ch = 2'(k);
    end
    for (int k = 3; k >= 0; k--) begin
      if (mask_q[k] && (k > int'(sel))) begin
        next_ch  = 2'(k);
        has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      mask_q <= 4'd0;
      sel    <= 2'd0;
      sample <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask_q <= mask;
            sample <= 4'd0;
            cnt    <= 8'd0;
            if (mask != 4'd0) begin
              state <= SCAN;
              sel   <= first_ch;
              busy  <= 1'b1;
              valid <= 1'b0;
            end else begin
              // Nothing to scan: report an empty, valid result at once.
              state <= FINISH;
              done  <= 1'b1;
              valid <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (cnt == CNT_SMP) sample[sel] <= y_in;
          if (cnt == CNT_LAST) begin
            cnt <= 8'd0;
            if (has_next) begin
              sel <= next_ch;
            end else begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
              valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed scans of mux_scan_ctrl checked every cycle
// against a time-based model, plus literal result/timing expectations.
module tb_mux_scan_ctrl;

  localparam int DWELL  = 4;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mask = 4'd0;
  logic       y_in = 1'b0;
  logic       sel0, sel1;
  logic [3:0] sample;
  logic       busy, done, valid;

  logic [3:0] pat = 4'd0;
  logic       noise = 1'b0;

  int total = 0;
  int bad = 0;

  mux_scan_ctrl #(.DWELL(DWELL), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .mask(mask), .y_in(y_in),
    .sel0(sel0), .sel1(sel1), .sample(sample),
    .busy(busy), .done(done), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [3:0] m);
    int n = 0;
    for (int k = 0; k < 4; k++) if (m[k]) n++;
    return n;
  endfunction

  // i-th enabled channel (0-based) in ascending order
  function automatic logic [1:0] nth_ch(input logic [3:0] m, input int i);
    int n = 0;
    logic [1:0] r = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        if (n == i) r = 2'(k);
        n++;
      end
    end
    return r;
  endfunction

  // Model: a scan with n channels is a run of n*DWELL busy cycles; cycle t
  // (1-based) drives channel (t-1)/DWELL and samples at offset SETTLE.
  logic       m_run = 1'b0;
  logic       m_fin = 1'b0;
  int         m_t = 0;
  int         m_n = 0;
  logic [3:0] m_mask = 4'd0;
  logic [1:0] m_sel = 2'd0;
  logic [3:0] m_sample = 4'd0;
  logic       m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run    <= 1'b0;
      m_fin    <= 1'b0;
      m_t      <= 0;
      m_n      <= 0;
      m_mask   <= 4'd0;
      m_sel    <= 2'd0;
      m_sample <= 4'd0;
      m_valid  <= 1'b0;
    end else if (!m_run && !m_fin) begin
      if (start) begin
        m_mask   <= mask;
        m_n      <= popc(mask);
        m_sample <= 4'd0;
        if (popc(mask) == 0) begin
          m_fin   <= 1'b1;
          m_valid <= 1'b1;
        end else begin
          m_run   <= 1'b1;
          m_t     <= 1;
          m_valid <= 1'b0;
          m_sel   <= nth_ch(mask, 0);
        end
      end
    end else if (m_run) begin
      if ((m_t - 1) % DWELL == SETTLE)
        m_sample[nth_ch(m_mask, (m_t - 1) / DWELL)] <= y_in;
      if (m_t == m_n * DWELL) begin
        m_run   <= 1'b0;
        m_fin   <= 1'b1;
        m_valid <= 1'b1;
      end else begin
        m_t   <= m_t + 1;
        m_sel <= nth_ch(m_mask, m_t / DWELL);
      end
    end else begin
      m_fin <= 1'b0;
    end
  end

  // Mux emulation; in noise mode y_in is inverted except in the settle slot.
  always @(negedge clk) begin
    y_in = pat[{sel1, sel0}] ^
           (noise && !(m_run && ((m_t - 1) % DWELL == SETTLE)));
  end

  always @(negedge clk) begin
    chk("sel", {30'd0, sel1, sel0}, {30'd0, m_sel});
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("done", {31'd0, done}, {31'd0, m_fin});
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("sample", {28'd0, sample}, {28'd0, m_sample});
  end

  task automatic run_scan(input string nm, input logic [3:0] m,
                          input logic [3:0] p, input logic nz,
                          input int exp_k, input int exp_busy,
                          input logic [3:0] exp_smp);
    int k;
    int nb = 0;
    @(negedge clk);
    pat   = p;
    noise = nz;
    mask  = m;
    start = 1'b1;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = nz && (k == 5);
      if (nz) mask = (k >= 5) ? ~m : m;
      if (busy) nb++;
      if (done) break;
    end
    noise = 1'b0;
    mask  = m;
    chk({nm, "_done_cycle"}, k, exp_k);
    chk({nm, "_busy_cycles"}, nb, exp_busy);
    chk({nm, "_sample"}, {28'd0, sample}, {28'd0, exp_smp});
    chk({nm, "_valid"}, {31'd0, valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int d1, d2, nd;
    repeat (2) @(negedge clk);
    chk("rst_outs", {23'd0, sel1, sel0, sample, busy, done, valid},
        32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_scan("full", 4'b1111, 4'b1101, 1'b0, 17, 16, 4'b1101);
    run_scan("sparse", 4'b0101, 4'b1111, 1'b0, 9, 8, 4'b0101);
    run_scan("empty", 4'b0000, 4'b1111, 1'b0, 1, 0, 4'b0000);
    run_scan("robust", 4'b1111, 4'b0110, 1'b1, 17, 16, 4'b0110);

    // start held high: second scan accepted in the IDLE after FINISH
    @(negedge clk);
    pat   = 4'b0011;
    mask  = 4'b0011;
    start = 1'b1;
    d1 = 0;
    d2 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = k;
        else begin
          d2 = k;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_done", d1, 9);
    chk("b2b_spacing", d2 - d1, 10);
    chk("b2b_sample", {28'd0, sample}, 32'h3);
    repeat (3) @(negedge clk);

    // abort mid-scan with an asynchronous reset
    @(negedge clk);
    pat   = 4'b1101;
    mask  = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1 chk("abort_outs", {23'd0, sel1, sel0, sample, busy, done, valid},
           32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_scan("after_abort", 4'b1111, 4'b1101, 1'b0, 17, 16, 4'b1101);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
